// File: rtl/mult_arbiter_pkg.sv
// Shared definitions for the two-client multiplier arbiter:
// FSM state encoding, client index width, timeout result and multiplier step count.
package mult_arbiter_pkg;

   localparam int CLIENT_W = 1;
   typedef logic [CLIENT_W-1:0] client_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Product reported to a client whose operation was aborted by the timeout
   localparam logic [15:0] TIMEOUT_RESULT = 16'hFFFF;

   // One shift-add step per operand bit
   localparam int MULT_STEPS = 8;

endpackage

// File: rtl/mult_arbiter_mult.sv
// Sequential 8x8 shift-add multiplier.
// start_i restarts the unit with fresh operands (abandoning any operation in flight);
// busy_o is high for MULT_STEPS cycles after the start edge, then y_bo holds the product.
module mult_arbiter_mult
   import mult_arbiter_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [7:0]  a_bi,
   input  logic [7:0]  b_bi,
   output logic        busy_o,
   output logic [15:0] y_bo
);

   logic [15:0] acc_q, acc_d;
   logic [15:0] a_sh_q, a_sh_d;
   logic [7:0]  b_sh_q, b_sh_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;

   // Next state: load on start, otherwise one shift-add step per cycle while busy
   always_comb begin
      acc_d  = acc_q;
      a_sh_d = a_sh_q;
      b_sh_d = b_sh_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      if (start_i) begin
         acc_d  = 16'd0;
         a_sh_d = {8'd0, a_bi};
         b_sh_d = b_bi;
         cnt_d  = 4'(MULT_STEPS);
         busy_d = 1'b1;
      end else if (busy_q) begin
         if (b_sh_q[0]) acc_d = acc_q + a_sh_q;
         a_sh_d = a_sh_q << 1;
         b_sh_d = b_sh_q >> 1;
         cnt_d  = cnt_q - 4'd1;
         busy_d = (cnt_q != 4'd1);
      end
   end

   // State registers
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         acc_q  <= 16'd0;
         a_sh_q <= 16'd0;
         b_sh_q <= 8'd0;
         cnt_q  <= 4'd0;
         busy_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         a_sh_q <= a_sh_d;
         b_sh_q <= b_sh_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign busy_o = busy_q;
   assign y_bo   = acc_q;

endmodule

// File: rtl/mult_arbiter.sv
// Two-client arbiter serialising multiplications through one shared multiplier.
// Flow: IDLE (grant + latch operands) -> START (one-cycle mult start)
//       -> WAIT (until mult idle or TIMEOUT) -> DONE (one-cycle ack) -> IDLE.
// Build option: define MULT_ARB_RR_EN for round-robin on simultaneous requests;
// otherwise client 0 has fixed priority.
module mult_arbiter
   import mult_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 31
)(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req0_i,
   input  logic [7:0]  a0_bi,
   input  logic [7:0]  b0_bi,
   output logic        ack0_o,
   output logic [15:0] y0_bo,
   input  logic        req1_i,
   input  logic [7:0]  a1_bi,
   input  logic [7:0]  b1_bi,
   output logic        ack1_o,
   output logic [15:0] y1_bo,
   output logic        err_o,
   output logic        busy_o
);

   // Value of the WAIT counter in the TIMEOUT-th WAIT cycle
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_e      state_q, state_d;
   client_t     gnt_q, gnt_d;
   logic [7:0]  a_q, a_d, b_q, b_d;
   logic        start_q, start_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] y0_q, y0_d, y1_q, y1_d;
   logic        ack0_q, ack0_d, ack1_q, ack1_d;
   logic        err_q, err_d;
   client_t     pick;

   logic        mult_busy;
   logic [15:0] mult_y;

`ifdef MULT_ARB_RR_EN
   // Last granted client; resets to 1 so client 0 wins the first contest
   client_t     last_q, last_d;

   // Round-robin: on contention, grant the client not granted last
   always_comb begin
      if (req0_i && req1_i) pick = ~last_q;
      else                  pick = req0_i ? client_t'(0) : client_t'(1);
   end
`else
   // Fixed priority: client 0 always wins
   always_comb begin
      pick = req0_i ? client_t'(0) : client_t'(1);
   end
`endif

   // FSM next-state, operand latch, result capture and registered output pulses
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      a_d     = a_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      y0_d    = y0_q;
      y1_d    = y1_q;
      start_d = 1'b0;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      err_d   = 1'b0;
`ifdef MULT_ARB_RR_EN
      last_d  = last_q;
`endif
      case (state_q)
         IDLE: begin
            cnt_d = 8'd0;
            if (req0_i || req1_i) begin
               gnt_d   = pick;
               a_d     = (pick == client_t'(1)) ? a1_bi : a0_bi;
               b_d     = (pick == client_t'(1)) ? b1_bi : b0_bi;
               start_d = 1'b1;
               state_d = START;
`ifdef MULT_ARB_RR_EN
               last_d  = pick;
`endif
            end
         end
         START: begin
            cnt_d   = 8'd0;
            state_d = WAIT;
         end
         WAIT: begin
            if (!mult_busy) begin
               if (gnt_q == client_t'(1)) y1_d = mult_y;
               else                       y0_d = mult_y;
               ack0_d  = (gnt_q == client_t'(0));
               ack1_d  = (gnt_q == client_t'(1));
               state_d = DONE;
            end else if (cnt_q == TO_LAST) begin
               if (gnt_q == client_t'(1)) y1_d = TIMEOUT_RESULT;
               else                       y0_d = TIMEOUT_RESULT;
               ack0_d  = (gnt_q == client_t'(0));
               ack1_d  = (gnt_q == client_t'(1));
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM and output registers
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         gnt_q   <= client_t'(0);
         a_q     <= 8'd0;
         b_q     <= 8'd0;
         start_q <= 1'b0;
         cnt_q   <= 8'd0;
         y0_q    <= 16'd0;
         y1_q    <= 16'd0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef MULT_ARB_RR_EN
         last_q  <= client_t'(1);
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         start_q <= start_d;
         cnt_q   <= cnt_d;
         y0_q    <= y0_d;
         y1_q    <= y1_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         err_q   <= err_d;
`ifdef MULT_ARB_RR_EN
         last_q  <= last_d;
`endif
      end
   end

   mult_arbiter_mult u_mult (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (start_q),
      .a_bi    (a_q),
      .b_bi    (b_q),
      .busy_o  (mult_busy),
      .y_bo    (mult_y)
   );

   assign ack0_o = ack0_q;
   assign ack1_o = ack1_q;
   assign y0_bo  = y0_q;
   assign y1_bo  = y1_q;
   assign err_o  = err_q;
   assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: directed scenarios plus randomized
// request rounds compared against a transaction-level model (products by
// arithmetic, fixed ack latency, last-granted client for round-robin builds).
// A second instance with TIMEOUT=8 exercises the abort path.
module tb_mult_arbiter;

`ifdef MULT_ARB_RR_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic        clk, rst_n;
   logic        req0, req1;
   logic [7:0]  a0, b0, a1, b1;
   logic        ack0, ack1, err, busy;
   logic [15:0] y0, y1;

   logic        t_req0, t_req1;
   logic [7:0]  t_a0, t_b0, t_a1, t_b1;
   logic        t_ack0, t_ack1, t_err, t_busy;
   logic [15:0] t_y0, t_y1;

   int checks = 0;
   int failures = 0;

   // Reference model state
   logic [15:0] my0, my1;
   int          last_gnt;

   mult_arbiter dut (
      .clk_i(clk), .rst_i(rst_n),
      .req0_i(req0), .a0_bi(a0), .b0_bi(b0), .ack0_o(ack0), .y0_bo(y0),
      .req1_i(req1), .a1_bi(a1), .b1_bi(b1), .ack1_o(ack1), .y1_bo(y1),
      .err_o(err), .busy_o(busy)
   );

   mult_arbiter #(.TIMEOUT(8)) dut_to (
      .clk_i(clk), .rst_i(rst_n),
      .req0_i(t_req0), .a0_bi(t_a0), .b0_bi(t_b0), .ack0_o(t_ack0), .y0_bo(t_y0),
      .req1_i(t_req1), .a1_bi(t_a1), .b1_bi(t_b1), .ack1_o(t_ack1), .y1_bo(t_y1),
      .err_o(t_err), .busy_o(t_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int pick_model(input bit p0, input bit p1);
      if (p0 && p1) return RR_EN ? (1 - last_gnt) : 0;
      return p0 ? 0 : 1;
   endfunction

   function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b);
      return 16'(int'(a) * int'(b));
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
      t_req0 = 0; t_req1 = 0; t_a0 = 0; t_b0 = 0; t_a1 = 0; t_b1 = 0;
      repeat (3) @(negedge clk);
      checks++; if ({ack0, ack1, err, busy} !== 4'b0) begin failures++;
         $display("FAIL reset_flags got=%b exp=0000", {ack0, ack1, err, busy}); end
      checks++; if (y0 !== 16'd0) begin failures++; $display("FAIL reset_y0 got=%0d exp=0", y0); end
      checks++; if (y1 !== 16'd0) begin failures++; $display("FAIL reset_y1 got=%0d exp=0", y1); end
      checks++; if ({t_ack0, t_ack1, t_err, t_busy} !== 4'b0) begin failures++;
         $display("FAIL reset_to_flags got=%b exp=0000", {t_ack0, t_ack1, t_err, t_busy}); end
      rst_n = 1'b1;
      my0 = 0; my1 = 0; last_gnt = 1;
      @(negedge clk);
   endtask

   task automatic test_single();
      a0 = 8'd7; b0 = 8'd9; req0 = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         if (c < 11) begin
            checks++; if (ack0 || ack1) begin failures++;
               $display("FAIL single_early_ack cycle=%0d ack0=%b ack1=%b", c, ack0, ack1); end
         end
      end
      checks++; if ({ack1, ack0} !== 2'b01) begin failures++;
         $display("FAIL single_ack got=%b exp=01", {ack1, ack0}); end
      checks++; if (y0 !== 16'd63) begin failures++; $display("FAIL single_y0 got=%0d exp=63", y0); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL single_err got=%b exp=0", err); end
      req0 = 1'b0; my0 = 16'd63; last_gnt = 0;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || ack0 !== 1'b0) begin failures++;
         $display("FAIL single_after busy=%b ack0=%b exp=0/0", busy, ack0); end
   endtask

   task automatic test_isolation();
      logic [15:0] ey;
      for (int r = 0; r < 2; r++) begin
         a1 = 8'($urandom); b1 = 8'($urandom); ey = prod(a1, b1); req1 = 1'b1;
         for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            checks++; if (y0 !== 16'd63) begin failures++;
               $display("FAIL iso_y0 cycle=%0d got=%0d exp=63", c, y0); end
            if (c < 11) begin
               checks++; if (ack0 || ack1) begin failures++;
                  $display("FAIL iso_early_ack cycle=%0d ack0=%b ack1=%b", c, ack0, ack1); end
            end
         end
         checks++; if ({ack1, ack0} !== 2'b10) begin failures++;
            $display("FAIL iso_ack got=%b exp=10", {ack1, ack0}); end
         checks++; if (y1 !== ey) begin failures++; $display("FAIL iso_y1 got=%0d exp=%0d", y1, ey); end
         req1 = 1'b0; my1 = ey; last_gnt = 1;
         @(negedge clk);
      end
   endtask

   task automatic test_operand_change();
      a1 = 8'd200; b1 = 8'd2; req1 = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         if (c == 4) a1 = 8'd0;
      end
      checks++; if ({ack1, ack0} !== 2'b10) begin failures++;
         $display("FAIL opchg_ack got=%b exp=10", {ack1, ack0}); end
      checks++; if (y1 !== 16'd400) begin failures++; $display("FAIL opchg_y1 got=%0d exp=400", y1); end
      req1 = 1'b0; my1 = 16'd400; last_gnt = 1;
      @(negedge clk);
   endtask

   task automatic test_simultaneous();
      int w, lat;
      logic [15:0] ey;
      a0 = 8'd3; b0 = 8'd5; a1 = 8'd12; b1 = 8'd12;
      req0 = 1'b1; req1 = 1'b1; lat = 11;
      for (int k = 0; k < 3; k++) begin
         w  = pick_model(1'b1, 1'b1);
         ey = (w == 0) ? 16'd15 : 16'd144;
         for (int c = 1; c <= lat; c++) @(negedge clk);
         checks++; if ({ack1, ack0} !== ((w == 0) ? 2'b01 : 2'b10)) begin failures++;
            $display("FAIL simul_ack k=%0d got=%b exp_client=%0d", k, {ack1, ack0}, w); end
         if (w == 0) my0 = ey; else my1 = ey;
         checks++; if (y0 !== my0 || y1 !== my1) begin failures++;
            $display("FAIL simul_y k=%0d got=%0d/%0d exp=%0d/%0d", k, y0, y1, my0, my1); end
         last_gnt = w; lat = 12;
      end
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      a0 = 8'd100; b0 = 8'd3; req0 = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b0; req0 = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if ({ack0, ack1, err, busy} !== 4'b0 || y0 !== 16'd0 || y1 !== 16'd0) begin failures++;
         $display("FAIL rstmid_outputs flags=%b y0=%0d y1=%0d exp=all 0", {ack0, ack1, err, busy}, y0, y1); end
      rst_n = 1'b1; my0 = 0; my1 = 0; last_gnt = 1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         checks++; if (ack0 || ack1 || busy) begin failures++;
            $display("FAIL rstmid_quiet cycle=%0d ack0=%b ack1=%b busy=%b exp=0", c, ack0, ack1, busy); end
      end
      a1 = 8'd255; b1 = 8'd255; req1 = 1'b1;
      for (int c = 1; c <= 11; c++) @(negedge clk);
      checks++; if ({ack1, ack0} !== 2'b10) begin failures++;
         $display("FAIL rstmid_ack got=%b exp=10", {ack1, ack0}); end
      checks++; if (y1 !== 16'd65025 || y0 !== 16'd0) begin failures++;
         $display("FAIL rstmid_y got=%0d/%0d exp=0/65025", y0, y1); end
      req1 = 1'b0; my1 = 16'd65025; last_gnt = 1;
      @(negedge clk);
   endtask

   task automatic test_timeout();
      t_a0 = 8'd13; t_b0 = 8'd17; t_req0 = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c < 10) begin
            checks++; if (t_ack0 || t_ack1 || t_err) begin failures++;
               $display("FAIL to_early cycle=%0d ack0=%b ack1=%b err=%b", c, t_ack0, t_ack1, t_err); end
         end
      end
      checks++; if ({t_err, t_ack1, t_ack0} !== 3'b101) begin failures++;
         $display("FAIL to_ack0_err got=%b exp=101", {t_err, t_ack1, t_ack0}); end
      checks++; if (t_y0 !== 16'hFFFF) begin failures++; $display("FAIL to_y0 got=%h exp=ffff", t_y0); end
      t_req0 = 1'b0;
      @(negedge clk);
      checks++; if (t_err !== 1'b0 || t_busy !== 1'b0) begin failures++;
         $display("FAIL to_after err=%b busy=%b exp=0/0", t_err, t_busy); end
      t_a1 = 8'($urandom); t_b1 = 8'($urandom); t_req1 = 1'b1;
      for (int c = 1; c <= 10; c++) @(negedge clk);
      checks++; if ({t_err, t_ack1, t_ack0} !== 3'b110) begin failures++;
         $display("FAIL to_ack1_err got=%b exp=110", {t_err, t_ack1, t_ack0}); end
      checks++; if (t_y1 !== 16'hFFFF || t_y0 !== 16'hFFFF) begin failures++;
         $display("FAIL to_y got=%h/%h exp=ffff/ffff", t_y0, t_y1); end
      t_req1 = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_random(input int n);
      int pat, w, lat;
      bit p0, p1;
      logic [15:0] ey;
      for (int r = 0; r < n; r++) begin
         @(negedge clk);
         checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rnd_idle round=%0d busy=%b exp=0", r, busy); end
         pat = $urandom_range(1, 3);
         a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
         p0 = pat[0]; p1 = pat[1]; req0 = p0; req1 = p1; lat = 11;
         while (p0 || p1) begin
            w  = pick_model(p0, p1);
            ey = (w == 0) ? prod(a0, b0) : prod(a1, b1);
            for (int c = 1; c <= lat; c++) begin
               @(negedge clk);
               if (c == 3) begin
                  if (w == 0) begin a0 = 8'($urandom); b0 = 8'($urandom); end
                  else        begin a1 = 8'($urandom); b1 = 8'($urandom); end
               end
               if (c < lat) begin
                  checks++; if (ack0 || ack1) begin failures++;
                     $display("FAIL rnd_early_ack round=%0d cycle=%0d ack0=%b ack1=%b", r, c, ack0, ack1); end
               end
            end
            checks++; if ({err, ack1, ack0} !== ((w == 0) ? 3'b001 : 3'b010)) begin failures++;
               $display("FAIL rnd_ack round=%0d got=%b exp_client=%0d", r, {err, ack1, ack0}, w); end
            if (w == 0) begin my0 = ey; req0 = 1'b0; p0 = 1'b0; end
            else        begin my1 = ey; req1 = 1'b0; p1 = 1'b0; end
            checks++; if (y0 !== my0 || y1 !== my1) begin failures++;
               $display("FAIL rnd_y round=%0d got=%0d/%0d exp=%0d/%0d", r, y0, y1, my0, my1); end
            last_gnt = w; lat = 12;
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_isolation();
      test_operand_change();
      test_simultaneous();
      test_reset_mid();
      test_timeout();
      test_random(24);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
